// File: rtl/frame_builder.sv
// frame_builder: packs a byte stream big-endian into 16-bit words, escapes
// payload words equal to TERM or ESC, closes each frame with TERM, and caps
// the payload so payload plus terminator always fits the capture RAM.
module frame_builder #(
  parameter int unsigned MAX_WORDS = 255,
  parameter logic [15:0] TERM      = 16'haabb,
  parameter logic [15:0] ESC       = 16'haab0
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        in_valid,
  input  logic [7:0]  in_data,
  input  logic        in_last,
  output logic        in_ready,
  output logic        we,
  output logic [15:0] dout,
  output logic        frame_done,
  output logic        ovf
);

  localparam int unsigned CW = $clog2(MAX_WORDS + 1);
  localparam logic [CW-1:0] MAX_CNT = CW'(MAX_WORDS);

  typedef enum logic [2:0] {S_HI, S_LO, S_ESC, S_TERM, S_DROP} state_t;

  state_t        state_q;
  logic [7:0]    hi_q;
  logic [CW-1:0] cnt_q;
  logic          last_q;
  logic          esc_term_q;   // escaped word was TERM (code 0001) rather than ESC (0000)
  logic          we_q;
  logic [15:0]   dout_q;
  logic          frame_done_q;
  logic          ovf_q;

  logic          accept;
  logic [15:0]   word_d;
  logic          needs_esc;
  logic [CW-1:0] room;
  logic          room_1;
  logic          room_2;

  // Upstream may only push while the FSM is in a byte-consuming state.
  assign in_ready = !rst && ((state_q == S_HI) || (state_q == S_LO) || (state_q == S_DROP));
  assign accept   = in_valid && in_ready;

  assign word_d    = {hi_q, in_data};
  assign needs_esc = (word_d == TERM) || (word_d == ESC);
  assign room      = MAX_CNT - cnt_q;
  assign room_1    = (room != '0);
  assign room_2    = (room > CW'(1));   // written this way so tiny counters still work

  // Frame FSM: consumes bytes, emits one word per cycle at most, all outputs registered.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q      <= S_HI;
      hi_q         <= 8'h00;
      cnt_q        <= '0;
      last_q       <= 1'b0;
      esc_term_q   <= 1'b0;
      we_q         <= 1'b0;
      dout_q       <= 16'h0000;
      frame_done_q <= 1'b0;
      ovf_q        <= 1'b0;
    end else begin
      we_q         <= 1'b0;
      frame_done_q <= 1'b0;
      case (state_q)
        S_HI: begin
          if (accept) begin
            hi_q  <= in_data;
            ovf_q <= 1'b0;
            if (in_last) begin
              // Odd-length frame: the lone high byte is padded with zero.
              if (room_1) begin
                we_q   <= 1'b1;
                dout_q <= {in_data, 8'h00};
                cnt_q  <= cnt_q + CW'(1);
              end else begin
                ovf_q <= 1'b1;
              end
              state_q <= S_TERM;
            end else begin
              state_q <= S_LO;
            end
          end
        end

        S_LO: begin
          if (accept) begin
            last_q <= in_last;
            if (needs_esc ? room_2 : room_1) begin
              we_q <= 1'b1;
              if (needs_esc) begin
                // Escape pair is written as a unit; the code word follows next cycle.
                dout_q     <= ESC;
                esc_term_q <= (word_d == TERM);
                cnt_q      <= cnt_q + CW'(2);
                state_q    <= S_ESC;
              end else begin
                dout_q  <= word_d;
                cnt_q   <= cnt_q + CW'(1);
                state_q <= in_last ? S_TERM : S_HI;
              end
            end else begin
              // No room: truncate the frame and swallow the rest of it.
              ovf_q   <= 1'b1;
              state_q <= in_last ? S_TERM : S_DROP;
            end
          end
        end

        S_ESC: begin
          we_q    <= 1'b1;
          dout_q  <= esc_term_q ? 16'h0001 : 16'h0000;
          state_q <= last_q ? S_TERM : S_HI;
        end

        S_TERM: begin
          we_q         <= 1'b1;
          dout_q       <= TERM;
          frame_done_q <= 1'b1;
          cnt_q        <= '0;
          last_q       <= 1'b0;
          state_q      <= S_HI;
        end

        S_DROP: begin
          if (accept && in_last) begin
            state_q <= S_TERM;
          end
        end

        default: state_q <= S_HI;
      endcase
    end
  end

  assign we         = we_q;
  assign dout       = dout_q;
  assign frame_done = frame_done_q;
  assign ovf        = ovf_q;

endmodule

// File: tb/tb_frame_builder.sv
// tb_frame_builder: drives two frame_builder instances (MAX_WORDS 255 and 3)
// with directed frames and checks every cycle against a frame-level model.
module tb_frame_builder;

  localparam logic [15:0] TERM = 16'haabb;
  localparam logic [15:0] ESC  = 16'haab0;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic        rst;
  logic        vld    [2];
  logic [7:0]  dat    [2];
  logic        lst    [2];
  logic        rdy    [2];
  logic        we_o   [2];
  logic [15:0] dout_o [2];
  logic        fd_o   [2];
  logic        ovf_o  [2];

  frame_builder #(.MAX_WORDS(255)) dut0 (
    .clk(clk), .rst(rst), .in_valid(vld[0]), .in_data(dat[0]), .in_last(lst[0]),
    .in_ready(rdy[0]), .we(we_o[0]), .dout(dout_o[0]), .frame_done(fd_o[0]), .ovf(ovf_o[0])
  );

  frame_builder #(.MAX_WORDS(3)) dut1 (
    .clk(clk), .rst(rst), .in_valid(vld[1]), .in_data(dat[1]), .in_last(lst[1]),
    .in_ready(rdy[1]), .we(we_o[1]), .dout(dout_o[1]), .frame_done(fd_o[1]), .ovf(ovf_o[1])
  );

  int total = 0;
  int bad   = 0;
  int cyc   = 0;

  // ---------------- frame-level model ----------------
  typedef struct {
    int          cyc;
    logic [15:0] w;
    bit          fd;
    bit          ov;
  } ev_t;

  int          mw        [2] = '{255, 3};
  ev_t         expq      [2][$];
  int          busyq     [2][$];
  logic [15:0] got       [2][$];
  bit          got_ovf   [2];
  bit          first_m   [2];
  bit          have_hi   [2];
  bit          drop_m    [2];
  bit          ovf_m     [2];
  logic [7:0]  hi_m      [2];
  int          cnt_m     [2];
  int          last_emit [2];

  function automatic void chk(string nm, int d, int act, int exp);
    total++;
    if (act != exp) begin
      bad++;
      $display("FAIL %s dut%0d: got %h want %h (cycle %0d)", nm, d, act, exp, cyc);
    end
  endfunction

  function automatic void model_reset();
    for (int d = 0; d < 2; d++) begin
      expq[d].delete();
      busyq[d].delete();
      first_m[d] = 1'b1;
      have_hi[d] = 1'b0;
      drop_m[d]  = 1'b0;
      ovf_m[d]   = 1'b0;
      cnt_m[d]   = 0;
    end
  endfunction

  function automatic void push_ev(int d, int t, logic [15:0] w, bit fd);
    ev_t e;
    e.cyc = t; e.w = w; e.fd = fd; e.ov = ovf_m[d];
    expq[d].push_back(e);
    last_emit[d] = t;
  endfunction

  // Terminator: upstream is stalled in the cycle before it appears.
  function automatic void push_term(int d, int t);
    busyq[d].push_back(t - 1);
    push_ev(d, t, TERM, 1'b1);
    cnt_m[d]   = 0;
    first_m[d] = 1'b1;
    drop_m[d]  = 1'b0;
    have_hi[d] = 1'b0;
  endfunction

  // One accepted byte at clock edge k; words are visible in the cycle after edge k.
  function automatic void model_accept(int d, logic [7:0] b, logic l, int k);
    logic [15:0] w;
    int need;
    if (first_m[d]) begin
      ovf_m[d]   = 1'b0;
      first_m[d] = 1'b0;
    end
    if (drop_m[d]) begin
      if (l) push_term(d, k + 1);
      return;
    end
    if (!have_hi[d]) begin
      if (!l) begin
        hi_m[d]    = b;
        have_hi[d] = 1'b1;
        return;
      end
      if (cnt_m[d] + 1 <= mw[d]) begin
        push_ev(d, k, {b, 8'h00}, 1'b0);
        cnt_m[d]++;
      end else begin
        ovf_m[d] = 1'b1;
      end
      push_term(d, k + 1);
      return;
    end
    have_hi[d] = 1'b0;
    w    = {hi_m[d], b};
    need = (w == TERM || w == ESC) ? 2 : 1;
    if (cnt_m[d] + need > mw[d]) begin
      ovf_m[d] = 1'b1;
      if (l) push_term(d, k + 1);
      else   drop_m[d] = 1'b1;
      return;
    end
    if (need == 2) begin
      push_ev(d, k, ESC, 1'b0);
      busyq[d].push_back(k);
      push_ev(d, k + 1, (w == TERM) ? 16'h0001 : 16'h0000, 1'b0);
    end else begin
      push_ev(d, k, w, 1'b0);
    end
    cnt_m[d] += need;
    if (l) push_term(d, last_emit[d] + 1);
  endfunction

  // Edge monitor: advance the cycle count and feed accepted bytes to the model.
  always @(posedge clk) begin
    cyc = cyc + 1;
    for (int d = 0; d < 2; d++) begin
      if (!rst && vld[d] && rdy[d]) model_accept(d, dat[d], lst[d], cyc);
    end
  end

  // Compare process: every cycle, on the falling edge.
  always @(negedge clk) begin : cmp
    ev_t e;
    bit  exp_we;
    bit  exp_rdy;
    for (int d = 0; d < 2; d++) begin
      if (rst) begin
        chk("rst_we",    d, int'(we_o[d]),  0);
        chk("rst_dout",  d, int'(dout_o[d]), 0);
        chk("rst_done",  d, int'(fd_o[d]),  0);
        chk("rst_ovf",   d, int'(ovf_o[d]), 0);
        chk("rst_ready", d, int'(rdy[d]),   0);
      end else begin
        while (busyq[d].size() > 0 && busyq[d][0] < cyc) void'(busyq[d].pop_front());
        exp_rdy = !(busyq[d].size() > 0 && busyq[d][0] == cyc);
        chk("in_ready", d, int'(rdy[d]), int'(exp_rdy));
        exp_we = (expq[d].size() > 0) && (expq[d][0].cyc == cyc);
        chk("we", d, int'(we_o[d]), int'(exp_we));
        if (exp_we) begin
          e = expq[d].pop_front();
          if (we_o[d]) begin
            chk("dout",       d, int'(dout_o[d]), int'(e.w));
            chk("frame_done", d, int'(fd_o[d]),   int'(e.fd));
            chk("ovf",        d, int'(ovf_o[d]),  int'(e.ov));
          end
        end else begin
          chk("done_idle", d, int'(fd_o[d]), 0);
        end
        if (we_o[d]) begin
          got[d].push_back(dout_o[d]);
          if (fd_o[d]) got_ovf[d] = ovf_o[d];
        end
      end
    end
  end

  // ---------------- stimulus helpers ----------------
  task automatic idle(input int n);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic send(input int d, input logic [7:0] b, input logic l);
    int   t;
    logic ok;
    vld[d] = 1'b1;
    dat[d] = b;
    lst[d] = l;
    t = 0;
    forever begin
      ok = rdy[d];
      @(posedge clk);
      #1;
      if (ok) break;
      t++;
      if (t > 50) begin
        total++;
        bad++;
        $display("FAIL send_timeout dut%0d: byte %h never accepted", d, b);
        break;
      end
    end
    vld[d] = 1'b0;
    dat[d] = 8'($urandom);
    lst[d] = 1'($urandom);
  endtask

  task automatic frame(input int d, input int n, input logic [7:0] b [12], input bit gap);
    for (int i = 0; i < n; i++) begin
      send(d, b[i], (i == n - 1));
      if (gap) idle(1 + (i % 2));
    end
    idle(5);
  endtask

  // Literal expectations for the words a frame produced.
  task automatic check_words(input int d, input string nm, input int n,
                             input logic [15:0] e [8], input bit ov);
    chk({nm, "_count"}, d, got[d].size(), n);
    for (int i = 0; i < n && i < got[d].size(); i++) chk(nm, d, int'(got[d][i]), int'(e[i]));
    chk({nm, "_ovf"}, d, int'(got_ovf[d]), int'(ov));
    chk({nm, "_pending"}, d, expq[d].size(), 0);
    got[d].delete();
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    rst = 1'b1;
    for (int d = 0; d < 2; d++) begin
      vld[d] = 1'b0; dat[d] = 8'h00; lst[d] = 1'b0;
      got_ovf[d] = 1'b0; last_emit[d] = 0;
    end
    model_reset();
    idle(3);
    rst = 1'b0;
    idle(2);

    // Basic frame, gap-free
    frame(0, 4, '{0:8'h11, 1:8'h22, 2:8'h33, 3:8'h44, default:8'h00}, 1'b0);
    check_words(0, "basic", 3, '{0:16'h1122, 1:16'h3344, 2:16'haabb, default:16'h0}, 1'b0);
    $display("basic frame checked");

    // Same bytes with gaps between them
    frame(0, 4, '{0:8'h11, 1:8'h22, 2:8'h33, 3:8'h44, default:8'h00}, 1'b1);
    check_words(0, "gaps", 3, '{0:16'h1122, 1:16'h3344, 2:16'haabb, default:16'h0}, 1'b0);
    $display("gapped frame checked");

    // Odd length
    frame(0, 3, '{0:8'h12, 1:8'h34, 2:8'h56, default:8'h00}, 1'b0);
    check_words(0, "odd", 3, '{0:16'h1234, 1:16'h5600, 2:16'haabb, default:16'h0}, 1'b0);
    $display("odd frame checked");

    // Escapes of TERM and ESC mid-frame
    frame(0, 6, '{0:8'haa, 1:8'hbb, 2:8'haa, 3:8'hb0, 4:8'h01, 5:8'h02, default:8'h00}, 1'b0);
    check_words(0, "escape", 6, '{0:16'haab0, 1:16'h0001, 2:16'haab0, 3:16'h0000,
                                   4:16'h0102, 5:16'haabb, default:16'h0}, 1'b0);
    $display("escape frame checked");

    // Near-miss word, then escape on the last pair
    frame(0, 4, '{0:8'haa, 1:8'hbc, 2:8'haa, 3:8'hbb, default:8'h00}, 1'b1);
    check_words(0, "esc_last", 4, '{0:16'haabc, 1:16'haab0, 2:16'h0001, 3:16'haabb,
                                     default:16'h0}, 1'b0);
    $display("escape-last frame checked");

    // Overflow, MAX_WORDS = 3
    frame(1, 8, '{0:8'h01, 1:8'h02, 2:8'h03, 3:8'h04, 4:8'h05, 5:8'h06, 6:8'h07, 7:8'h08,
                  default:8'h00}, 1'b0);
    check_words(1, "ovf", 4, '{0:16'h0102, 1:16'h0304, 2:16'h0506, 3:16'haabb,
                                default:16'h0}, 1'b1);
    $display("overflow frame checked");

    // Overflow on an escape pair
    frame(1, 6, '{0:8'h01, 1:8'h02, 2:8'h03, 3:8'h04, 4:8'haa, 5:8'hbb, default:8'h00}, 1'b0);
    check_words(1, "ovf_esc", 3, '{0:16'h0102, 1:16'h0304, 2:16'haabb, default:16'h0}, 1'b1);
    $display("overflow-on-escape frame checked");

    // Next frame clears the sticky flag
    frame(1, 2, '{0:8'h01, 1:8'h02, default:8'h00}, 1'b0);
    check_words(1, "recover", 2, '{0:16'h0102, 1:16'haabb, default:16'h0}, 1'b0);
    $display("recovery frame checked");

    // Overflow followed by dropped bytes, with gaps
    frame(1, 10, '{0:8'h01, 1:8'h02, 2:8'h03, 3:8'h04, 4:8'h05, 5:8'h06, 6:8'h07, 7:8'h08,
                   8:8'h09, 9:8'h0a, default:8'h00}, 1'b1);
    check_words(1, "drop", 4, '{0:16'h0102, 1:16'h0304, 2:16'h0506, 3:16'haabb,
                                 default:16'h0}, 1'b1);
    $display("drop frame checked");

    // Overflow on the odd pad word
    frame(1, 7, '{0:8'h01, 1:8'h02, 2:8'h03, 3:8'h04, 4:8'h05, 5:8'h06, 6:8'h07,
                  default:8'h00}, 1'b0);
    check_words(1, "ovf_pad", 4, '{0:16'h0102, 1:16'h0304, 2:16'h0506, 3:16'haabb,
                                    default:16'h0}, 1'b1);
    $display("pad-overflow frame checked");

    // Reset mid-frame: dut0 holds 1122 on dout, dut1 holds a sticky ovf
    send(0, 8'h11, 1'b0);
    send(0, 8'h22, 1'b0);
    send(0, 8'h33, 1'b0);
    rst = 1'b1;
    model_reset();
    #1;
    chk("rst_now_dout", 0, int'(dout_o[0]), 0);
    chk("rst_now_we",   0, int'(we_o[0]),   0);
    chk("rst_now_ovf",  1, int'(ovf_o[1]),  0);
    chk("rst_now_dout", 1, int'(dout_o[1]), 0);
    idle(2);
    rst = 1'b0;
    got[0].delete();
    got[1].delete();
    idle(1);
    frame(0, 2, '{0:8'h44, 1:8'h55, default:8'h00}, 1'b0);
    check_words(0, "after_rst", 2, '{0:16'h4455, 1:16'haabb, default:16'h0}, 1'b0);
    $display("reset recovery frame checked");

    idle(3);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
